// File: rtl/nasti_stream_pkt_fifo.sv
// nasti_stream_pkt_fifo
// Arbitrary-depth NASTI-stream FIFO. Cut-through by default; with
// PACKET_MODE=1 it releases a packet only once its t_last beat is stored.
// If the buffer fills while holding no complete packet, it falls back to
// cut-through until that oversize packet's t_last beat has drained.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_NORMAL  | dest gated on a complete packet being held (packet mode)
// ST_FORCED  | buffer filled with no complete packet; cut-through until the
//            | t_last beat is read out
module nasti_stream_pkt_fifo #(
  parameter int ID_WIDTH     = 1,
  parameter int DEST_WIDTH   = 1,
  parameter int USER_WIDTH   = 1,
  parameter int DATA_WIDTH   = 64,
  parameter int BUF_SIZE     = 16,
  parameter int PACKET_MODE  = 0,
  parameter int AFULL_THRESH = BUF_SIZE - 2
) (
  input  logic                             aclk,
  input  logic                             areset,
  // upstream stream
  input  logic                             src_t_valid,
  output logic                             src_t_ready,
  input  logic [DATA_WIDTH-1:0]            src_t_data,
  input  logic [DATA_WIDTH/8-1:0]          src_t_strb,
  input  logic [DATA_WIDTH/8-1:0]          src_t_keep,
  input  logic                             src_t_last,
  input  logic [ID_WIDTH-1:0]              src_t_id,
  input  logic [DEST_WIDTH-1:0]            src_t_dest,
  input  logic [USER_WIDTH-1:0]            src_t_user,
  // downstream stream
  output logic                             dest_t_valid,
  input  logic                             dest_t_ready,
  output logic [DATA_WIDTH-1:0]            dest_t_data,
  output logic [DATA_WIDTH/8-1:0]          dest_t_strb,
  output logic [DATA_WIDTH/8-1:0]          dest_t_keep,
  output logic                             dest_t_last,
  output logic [ID_WIDTH-1:0]              dest_t_id,
  output logic [DEST_WIDTH-1:0]            dest_t_dest,
  output logic [USER_WIDTH-1:0]            dest_t_user,
  // status
  output logic [$clog2(BUF_SIZE+1)-1:0]    level,
  output logic [$clog2(BUF_SIZE+1)-1:0]    pkt_count,
  output logic                             almost_full,
  output logic                             overflow_cut
);

  localparam int STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH   = $clog2(BUF_SIZE + 1);
  localparam int PTR_WIDTH   = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam int ENTRY_WIDTH = 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH
                               + 2 * STRB_WIDTH + DATA_WIDTH;

  localparam logic [CNT_WIDTH-1:0] FULL_LVL  = CNT_WIDTH'(BUF_SIZE);
  localparam logic [CNT_WIDTH-1:0] AFULL_LVL = CNT_WIDTH'(AFULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(BUF_SIZE - 1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCED = 1'b1
  } cut_state_e;

  logic [ENTRY_WIDTH-1:0] mem [BUF_SIZE];
  logic [ENTRY_WIDTH-1:0] wr_entry;
  logic [ENTRY_WIDTH-1:0] rd_entry;

  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [CNT_WIDTH-1:0]   level_q;
  logic [CNT_WIDTH-1:0]   level_d;
  logic [CNT_WIDTH-1:0]   pkt_count_q;
  logic [CNT_WIDTH-1:0]   pkt_count_d;
  logic                   almost_full_q;
  cut_state_e             state_q;
  cut_state_e             state_d;

  logic                   w_fire;
  logic                   r_fire;
  logic                   w_last;
  logic                   r_last;

  // Depth need not be a power of two, so wrap explicitly at the last entry.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  // No write-through: a full buffer refuses input even if dest reads this cycle.
  assign src_t_ready = (level_q != FULL_LVL);
  assign w_fire      = src_t_valid & src_t_ready;
  assign r_fire      = dest_t_valid & dest_t_ready;
  assign w_last      = w_fire & src_t_last;
  assign r_last      = r_fire & dest_t_last;

  assign wr_entry = {src_t_last, src_t_id, src_t_dest, src_t_user,
                     src_t_keep, src_t_strb, src_t_data};
  assign rd_entry = mem[rd_ptr];
  assign {dest_t_last, dest_t_id, dest_t_dest, dest_t_user,
          dest_t_keep, dest_t_strb, dest_t_data} = rd_entry;

  assign level       = level_q;
  assign pkt_count   = pkt_count_q;
  assign almost_full = almost_full_q;

  // Beat storage; contents need no reset because level gates visibility.
  always_ff @(posedge aclk) begin
    if (w_fire) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Output valid: any stored beat in cut-through, a complete packet otherwise.
  always_comb begin
    dest_t_valid = 1'b0;
    if (level_q != '0) begin
      if (PACKET_MODE == 0) begin
        dest_t_valid = 1'b1;
      end else begin
        dest_t_valid = (pkt_count_q != '0) | (state_q == ST_FORCED);
      end
    end
  end

  // Occupancy and packet counters; simultaneous push/pop cancel out.
  always_comb begin
    level_d     = level_q;
    pkt_count_d = pkt_count_q;
    if (w_fire && !r_fire) begin
      level_d = level_q + CNT_ONE;
    end else if (r_fire && !w_fire) begin
      level_d = level_q - CNT_ONE;
    end
    if (w_last && !r_last) begin
      pkt_count_d = pkt_count_q + CNT_ONE;
    end else if (r_last && !w_last) begin
      pkt_count_d = pkt_count_q - CNT_ONE;
    end
  end

  // Deadlock guard: full with no complete packet would stall both sides forever.
  always_comb begin
    state_d      = state_q;
    overflow_cut = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if ((PACKET_MODE != 0) && (level_q == FULL_LVL) && (pkt_count_q == '0)) begin
          state_d      = ST_FORCED;
          overflow_cut = 1'b1;
        end
      end
      ST_FORCED: begin
        if (r_last) begin
          state_d = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Pointers, counters, status flag and cut state.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_q       <= '0;
      pkt_count_q   <= '0;
      almost_full_q <= 1'b0;
      state_q       <= ST_NORMAL;
    end else begin
      if (w_fire) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (r_fire) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      level_q       <= level_d;
      pkt_count_q   <= pkt_count_d;
      almost_full_q <= (level_d >= AFULL_LVL);
      state_q       <= state_d;
    end
  end

endmodule

// File: tb/tb_nasti_stream_pkt_fifo.sv
// Bench for nasti_stream_pkt_fifo. Three instances share clock and reset:
//   0: BUF_SIZE=16 cut-through, 1: BUF_SIZE=16 packet mode, 2: BUF_SIZE=6 cut-through.
// A negedge monitor keeps one expected-beat queue per instance.
module tb_nasti_stream_pkt_fifo;

  typedef struct packed {
    logic        last;
    logic        id;
    logic        tdest;
    logic        user;
    logic [7:0]  strb;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  typedef struct {
    logic v;
    logic last;
    int   n;
    logic rdy;
    int   e_lvl;
    int   e_pkt;
    logic e_srdy;
    logic e_afull;
    logic e_dval;
  } vec_t;

  logic       aclk;
  logic       areset;
  logic       src_v   [3];
  beat_t      src_b   [3];
  logic       s_rdy   [3];
  logic       d_rdy   [3];
  logic       d_valid [3];
  beat_t      dst_b   [3];
  logic [4:0] lvl     [3];
  logic [4:0] pkt     [3];
  logic       afull   [3];
  logic       ovf     [3];

  beat_t      sbq [3][$];
  int         ovf_cnt [3];
  int         ovf_lvl [3];
  int         n_vec;
  int         n_err;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BS = (g == 2) ? 6 : 16;
    localparam int PM = (g == 1) ? 1 : 0;
    localparam int CW = $clog2(BS + 1);
    logic [CW-1:0] lvl_w;
    logic [CW-1:0] pkt_w;
    logic [63:0]   o_data;
    logic [7:0]    o_strb;
    logic [7:0]    o_keep;
    logic          o_last, o_id, o_dest, o_user;
    logic          o_valid, o_ready, o_af, o_ovf;

    nasti_stream_pkt_fifo #(
      .BUF_SIZE    (BS),
      .PACKET_MODE (PM)
    ) u_dut (
      .aclk         (aclk),
      .areset       (areset),
      .src_t_valid  (src_v[g]),
      .src_t_ready  (o_ready),
      .src_t_data   (src_b[g].data),
      .src_t_strb   (src_b[g].strb),
      .src_t_keep   (src_b[g].keep),
      .src_t_last   (src_b[g].last),
      .src_t_id     (src_b[g].id),
      .src_t_dest   (src_b[g].tdest),
      .src_t_user   (src_b[g].user),
      .dest_t_valid (o_valid),
      .dest_t_ready (d_rdy[g]),
      .dest_t_data  (o_data),
      .dest_t_strb  (o_strb),
      .dest_t_keep  (o_keep),
      .dest_t_last  (o_last),
      .dest_t_id    (o_id),
      .dest_t_dest  (o_dest),
      .dest_t_user  (o_user),
      .level        (lvl_w),
      .pkt_count    (pkt_w),
      .almost_full  (o_af),
      .overflow_cut (o_ovf)
    );

    assign s_rdy[g]   = o_ready;
    assign d_valid[g] = o_valid;
    assign dst_b[g]   = {o_last, o_id, o_dest, o_user, o_strb, o_keep, o_data};
    assign lvl[g]     = 5'(lvl_w);
    assign pkt[g]     = 5'(pkt_w);
    assign afull[g]   = o_af;
    assign ovf[g]     = o_ovf;
  end

  function automatic beat_t mk_beat(input int n, input logic last);
    beat_t b;
    b.data  = {32'(n * 7) ^ 32'hA5A5_0000, 32'(n)};
    b.strb  = 8'(n);
    b.keep  = ~8'(n);
    b.id    = n[0];
    b.tdest = n[1];
    b.user  = n[2];
    b.last  = last;
    return b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send(input int g, input beat_t b);
    bit acc;
    src_b[g] = b;
    src_v[g] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      acc = s_rdy[g];
      step();
      if (acc) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL send_timeout inst%0d: got no acceptance, expected one within 200 cycles", g);
  endtask

  task automatic drain(input int g, input string nm);
    d_rdy[g] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (sbq[g].size() == 0 && !d_valid[g]) break;
      step();
    end
    chk({nm, "_queue_empty"}, sbq[g].size(), 0);
    chk({nm, "_level_zero"}, 32'(lvl[g]), 0);
  endtask

  // Scoreboard: compare popped beats on read fire, push on write fire.
  always @(negedge aclk) begin
    for (int g = 0; g < 3; g++) begin
      if (areset) begin
        sbq[g].delete();
      end else begin
        if (ovf[g]) begin
          ovf_cnt[g]++;
          ovf_lvl[g] = 32'(lvl[g]);
        end
        if (d_valid[g] && d_rdy[g]) begin
          n_vec++;
          if (sbq[g].size() == 0) begin
            n_err++;
            $display("FAIL unexpected_beat inst%0d: got data=%h, expected no output", g, dst_b[g].data);
          end else begin
            beat_t e;
            e = sbq[g].pop_front();
            if (dst_b[g] !== e) begin
              n_err++;
              $display("FAIL beat inst%0d: got %h, expected %h", g, dst_b[g], e);
            end
          end
        end
        if (src_v[g] && s_rdy[g]) sbq[g].push_back(src_b[g]);
      end
    end
  end

  vec_t vt[$];

  initial begin
    vec_t v;
    int   sent;
    int   cyc;
    bit   acc;

    n_vec = 0;
    n_err = 0;

    // Fill/drain table for instance 0 (16 deep, cut-through, last every 4th beat).
    for (int k = 0; k < 16; k++) begin
      v = '{v: 1'b1, last: (k % 4 == 3), n: k, rdy: 1'b0,
            e_lvl: k + 1, e_pkt: (k + 1) / 4, e_srdy: (k != 15),
            e_afull: (k + 1 >= 14), e_dval: 1'b1};
      vt.push_back(v);
    end
    v = '{v: 1'b1, last: 1'b0, n: 99, rdy: 1'b0, e_lvl: 16, e_pkt: 4,
          e_srdy: 1'b0, e_afull: 1'b1, e_dval: 1'b1};
    vt.push_back(v);
    for (int j = 0; j < 16; j++) begin
      v = '{v: 1'b0, last: 1'b0, n: 0, rdy: 1'b1,
            e_lvl: 15 - j, e_pkt: 4 - (j + 1) / 4, e_srdy: 1'b1,
            e_afull: (15 - j >= 14), e_dval: (j != 15)};
      vt.push_back(v);
    end

    // Reset held two cycles with valid asserted on every instance.
    areset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      src_v[g]   = 1'b1;
      src_b[g]   = mk_beat(1000 + g, 1'b1);
      d_rdy[g]   = 1'b0;
      ovf_cnt[g] = 0;
      ovf_lvl[g] = 0;
    end
    step();
    step();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_dvalid%0d", g), 32'(d_valid[g]), 0);
      chk($sformatf("rst_srdy%0d", g), 32'(s_rdy[g]), 1);
      chk($sformatf("rst_level%0d", g), 32'(lvl[g]), 0);
      chk($sformatf("rst_pkt%0d", g), 32'(pkt[g]), 0);
    end
    areset = 1'b0;
    for (int g = 0; g < 3; g++) src_v[g] = 1'b0;
    step();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("post_rst_level%0d", g), 32'(lvl[g]), 0);
      chk($sformatf("post_rst_afull%0d", g), 32'(afull[g]), 0);
    end

    // Table-driven fill/drain on instance 0.
    foreach (vt[i]) begin
      src_b[0] = mk_beat(vt[i].n, vt[i].last);
      src_v[0] = vt[i].v;
      d_rdy[0] = vt[i].rdy;
      step();
      chk($sformatf("vec%0d_level", i), 32'(lvl[0]), vt[i].e_lvl);
      chk($sformatf("vec%0d_pkt", i), 32'(pkt[0]), vt[i].e_pkt);
      chk($sformatf("vec%0d_srdy", i), 32'(s_rdy[0]), 32'(vt[i].e_srdy));
      chk($sformatf("vec%0d_afull", i), 32'(afull[0]), 32'(vt[i].e_afull));
      chk($sformatf("vec%0d_dvalid", i), 32'(d_valid[0]), 32'(vt[i].e_dval));
    end
    chk("fill_drain_queue_empty", sbq[0].size(), 0);

    // Packet hold on instance 1: nothing leaves until t_last is stored.
    d_rdy[1] = 1'b1;
    send(1, mk_beat(100, 1'b0));
    chk("hold_b0_dvalid", 32'(d_valid[1]), 0);
    send(1, mk_beat(101, 1'b0));
    chk("hold_b1_dvalid", 32'(d_valid[1]), 0);
    chk("hold_b1_level", 32'(lvl[1]), 2);
    send(1, mk_beat(102, 1'b1));
    src_v[1] = 1'b0;
    chk("hold_b2_dvalid", 32'(d_valid[1]), 1);
    chk("hold_b2_pkt", 32'(pkt[1]), 1);
    for (int r = 0; r < 3; r++) begin
      step();
      chk($sformatf("hold_rd%0d_level", r), 32'(lvl[1]), 2 - r);
      chk($sformatf("hold_rd%0d_pkt", r), 32'(pkt[1]), (r == 2) ? 0 : 1);
      chk($sformatf("hold_rd%0d_dvalid", r), 32'(d_valid[1]), (r == 2) ? 0 : 1);
    end

    // Oversize 20-beat packet on instance 1 forces cut-through once.
    ovf_cnt[1] = 0;
    for (int k = 0; k < 20; k++) send(1, mk_beat(200 + k, (k == 19)));
    src_v[1] = 1'b0;
    drain(1, "oversize");
    chk("oversize_ovf_pulses", ovf_cnt[1], 1);
    chk("oversize_ovf_level", ovf_lvl[1], 16);
    send(1, mk_beat(230, 1'b0));
    chk("after_cut_hold_dvalid", 32'(d_valid[1]), 0);
    send(1, mk_beat(231, 1'b1));
    src_v[1] = 1'b0;
    chk("after_cut_release_dvalid", 32'(d_valid[1]), 1);
    drain(1, "after_cut");

    // Random valid/ready stream through the 6-deep instance.
    sent = 0;
    cyc  = 0;
    while (sent < 50 && cyc < 3000) begin
      src_b[2] = mk_beat(400 + sent, (sent % 5 == 4));
      src_v[2] = ($urandom_range(0, 3) != 0);
      d_rdy[2] = ($urandom_range(0, 2) != 0);
      acc = src_v[2] & s_rdy[2];
      step();
      if (acc) sent++;
      cyc++;
    end
    src_v[2] = 1'b0;
    chk("random_beats_sent", sent, 50);
    drain(2, "random");

    // Steady level 3 with push and pop every cycle.
    d_rdy[2] = 1'b0;
    for (int k = 0; k < 3; k++) send(2, mk_beat(500 + k, 1'b0));
    d_rdy[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      src_b[2] = mk_beat(510 + k, (k == 9));
      src_v[2] = 1'b1;
      step();
      chk($sformatf("steady%0d_level", k), 32'(lvl[2]), 3);
    end
    src_v[2] = 1'b0;
    drain(2, "steady");

    // Reset in the middle of a packet on instance 1.
    for (int k = 0; k < 4; k++) send(1, mk_beat(600 + k, 1'b0));
    src_v[1] = 1'b0;
    chk("midpkt_level_before", 32'(lvl[1]), 4);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("midpkt_level", 32'(lvl[1]), 0);
    chk("midpkt_pkt", 32'(pkt[1]), 0);
    chk("midpkt_dvalid", 32'(d_valid[1]), 0);
    send(1, mk_beat(700, 1'b0));
    send(1, mk_beat(701, 1'b1));
    src_v[1] = 1'b0;
    drain(1, "midpkt");
    repeat (8) step();
    chk("midpkt_no_stale", sbq[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nasti_stream_pkt_fifo.md
Name: nasti_stream_pkt_fifo

Overview:
Parametrised NASTI-stream FIFO that generalises the single-mode stream buffer. Depth is arbitrary (not limited to powers of two). Adds a selectable store-and-forward packet mode, fill-level and packet-count status, and a programmable almost-full flag. It sits between any two nasti_stream_channel endpoints, for example DMA-to-NIC or NIC-to-host paths, where whole-packet release or back-pressure visibility is needed.

Parameters:
ID_WIDTH, 1, width of t_id
DEST_WIDTH, 1, width of t_dest
USER_WIDTH, 1, width of t_user
DATA_WIDTH, 64, width of t_data; t_strb and t_keep are DATA_WIDTH/8
BUF_SIZE, 16, number of beat entries; any value >= 2
PACKET_MODE, 0, 0 = cut-through; 1 = store-and-forward on t_last
AFULL_THRESH, BUF_SIZE-2, level at or above which almost_full asserts

Ports:
aclk  input  1  clock; all logic on rising edge
areset  input  1  synchronous, active-high reset
src  nasti_stream_channel.slave  -  upstream stream (t_valid, t_ready, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user)
dest  nasti_stream_channel.master  -  downstream stream, same fields
level  output  $clog2(BUF_SIZE+1)  beats currently stored
pkt_count  output  $clog2(BUF_SIZE+1)  complete packets (stored t_last beats) currently held
almost_full  output  1  level >= AFULL_THRESH
overflow_cut  output  1  pulse: packet mode forced cut-through because the buffer is full with no complete packet

Behaviour:
- Reset (areset high at a clock edge): read/write pointers = 0; level = 0; pkt_count = 0; dest.t_valid = 0; src.t_ready = 1; almost_full = 0; overflow_cut = 0; forced-cut state cleared. Buffer contents are don't-care. Reset mid-transfer discards all stored beats, including partial packets.
- w_fire = src.t_valid & src.t_ready; r_fire = dest.t_valid & dest.t_ready.
- src.t_ready = (level != BUF_SIZE). There is no write-through when full, even if dest reads in the same cycle.
- Pointers increment modulo BUF_SIZE, wrapping explicitly from BUF_SIZE-1 to 0. Level counting:
  - +1 on w_fire only
  - -1 on r_fire only
  - unchanged when both fire
- pkt_count counting:
  - +1 on w_fire with src.t_last
  - -1 on r_fire with dest.t_last
  - unchanged when both fire
- Stored fields are data, strb, keep, last, id, dest and user. Ordering is strictly FIFO.
- dest fields present the entry at the read pointer and are valid whenever dest.t_valid = 1. They stay stable while t_valid & !t_ready (AXI-stream rule).
- Latency: a beat written at edge N is presentable at dest from cycle N+1 (one-cycle minimum latency). No same-cycle bypass.
- PACKET_MODE=0: dest.t_valid = (level != 0).
- PACKET_MODE=1: dest.t_valid = (level != 0) & (pkt_count != 0 | forced_cut).
  - forced_cut sets when level == BUF_SIZE and pkt_count == 0. This is a deadlock guard; overflow_cut pulses for exactly one cycle at that moment.
  - forced_cut clears on r_fire of a t_last beat, or on reset.
  - While forced_cut is set, the FIFO behaves as cut-through.
  - The first beat of a packet that arrives later is held until that packet's t_last is written.
- almost_full and level are registered and reflect the state after the latest edge.
- Simultaneous w_fire and r_fire at level 0 cannot occur, because valid is low. At level BUF_SIZE, w_fire cannot occur.

Test Plan:
- Reset values: hold areset 2 cycles with src.t_valid=1 -> dest.t_valid=0, src.t_ready=1, level=0, pkt_count=0, no beat accepted during reset.
- Fill/drain, BUF_SIZE=16, PACKET_MODE=0, dest.t_ready=0: push data 0..15 -> src.t_ready drops after the 16th beat, level=16, almost_full set at level 14. Then set ready=1 -> dest shows 0..15 in order with t_last/id/user preserved, and level returns to 0.
- Packet hold, PACKET_MODE=1: push a 3-beat packet with t_last on beat 3 (dest.t_ready=1) -> dest.t_valid stays 0 until the cycle after beat 3 is written, then 3 consecutive beats are delivered. pkt_count goes 1 -> 0.
- Oversize packet, PACKET_MODE=1, BUF_SIZE=16: push a 20-beat packet -> overflow_cut pulses once when level reaches 16, and all 20 beats arrive in order. forced_cut clears after the t_last read, and a following 2-beat packet is held until its last beat.
- Wrap and simultaneity, BUF_SIZE=6 (not a power of two): stream 50 beats with random valid/ready -> no loss or duplication, and pointers wrap 5 -> 0. At a steady level of 3 with both sides firing every cycle, level stays 3.
- Reset mid-packet: after 4 beats of a 6-beat packet, pulse areset -> level=0, pkt_count=0, and no stale beats are ever emitted afterwards.
